// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
//   Shared types and helpers for the matrix-multiply compute block.
//   - state_e : controller state encoding (IDLE, MAC, OUT, DONE)
//   - outw_f  : result width that cannot overflow for an inner dimension of
//               up to maxk signed inw x inw products.
// -----------------------------------------------------------------------------
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_e;

  // A full-precision product needs 2*inw bits; summing maxk of them grows
  // the magnitude by at most clog2(maxk) bits.
  function automatic int outw_f(input int inw, input int maxk);
    return 2 * inw + $clog2(maxk);
  endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
//   Registered signed multiply-accumulate.
//   Ports:
//     clk    - clock, rising edge
//     reset  - synchronous, active-low
//     clr    - zero the accumulator on the next edge (wins over en)
//     en     - add a_i*b_i into the accumulator on the next edge
//     a_i    - signed INW-bit operand
//     b_i    - signed INW-bit operand
//     sum_o  - value the accumulator takes on the next edge when clr==0
//              (accumulator plus product when en, accumulator otherwise)
// -----------------------------------------------------------------------------
module mac_unit #(
  parameter int INW  = 12,
  parameter int OUTW = 27
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [INW-1:0]  a_i,
  input  logic signed [INW-1:0]  b_i,
  output logic signed [OUTW-1:0] sum_o
);

  logic signed [2*INW-1:0] prod;
  logic signed [OUTW-1:0]  acc_d;
  logic signed [OUTW-1:0]  acc_q;

  // NOTE: every variable written here gets a value before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    prod  = a_i * b_i;
    sum_o = acc_q;
    if (en) begin
      sum_o = acc_q + OUTW'(prod);
    end
    acc_d = clr ? '0 : sum_o;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matmul_compute.sv
// -----------------------------------------------------------------------------
// matmul_compute
//   Computes C = A x B (A: M x K, B: K x N, both signed INW-bit, read from
//   external synchronous memories with one cycle of read latency) and streams
//   C row-major over an AXI-Stream style output.
//   Ports:
//     clk              - clock, rising edge
//     reset            - synchronous, active-low
//     matrices_loaded  - A and B memories hold valid data; starts a compute
//     K                - inner dimension, captured when a compute starts
//     A_read_addr      - A address, row-major m*K+k (0 when not fetching)
//     A_data           - A read data, one cycle after its address
//     B_read_addr      - B address, row-major k*N+n (0 when not fetching)
//     B_data           - B read data, one cycle after its address
//     compute_finished - one-cycle pulse after the last element is accepted
//     AXIS_OUT_TDATA   - result element C[m][n]
//     AXIS_OUT_TVALID  - TDATA valid, held until accepted
//     AXIS_OUT_TREADY  - downstream accepts
//   Build option:
//     MATMUL_RELU_EN   - when defined, negative results are forced to 0
//                        before the output register (same latency).
// -----------------------------------------------------------------------------
module matmul_compute
  import matmul_pkg::*;
#(
  parameter int INW  = 12,
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int A_ADDR_BITS = $clog2(M * MAXK),
  localparam int B_ADDR_BITS = $clog2(MAXK * N),
  localparam int OUTW        = outw_f(INW, MAXK)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          matrices_loaded,
  input  logic [K_BITS-1:0]             K,
  output logic [A_ADDR_BITS-1:0]        A_read_addr,
  input  logic signed [INW-1:0]         A_data,
  output logic [B_ADDR_BITS-1:0]        B_read_addr,
  input  logic signed [INW-1:0]         B_data,
  output logic                          compute_finished,
  output logic signed [OUTW-1:0]        AXIS_OUT_TDATA,
  output logic                          AXIS_OUT_TVALID,
  input  logic                          AXIS_OUT_TREADY
);

  localparam int M_BITS = (M > 1) ? $clog2(M) : 1;
  localparam int N_BITS = (N > 1) ? $clog2(N) : 1;

  state_e                  state_d, state_q;
  logic [M_BITS-1:0]       m_d, m_q;
  logic [N_BITS-1:0]       n_d, n_q;
  logic [K_BITS-1:0]       k_d, k_q;
  logic [K_BITS-1:0]       k_lim_d, k_lim_q;
  logic signed [OUTW-1:0]  tdata_d, tdata_q;
  logic                    tvalid_d, tvalid_q;
  logic                    fin_d, fin_q;

  logic                    mac_clr;
  logic                    mac_en;
  logic signed [OUTW-1:0]  mac_sum;

  function automatic logic signed [OUTW-1:0] relu(input logic signed [OUTW-1:0] v);
`ifdef MATMUL_RELU_EN
    return v[OUTW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  mac_unit #(
    .INW  (INW),
    .OUTW (OUTW)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .a_i   (A_data),
    .b_i   (B_data),
    .sum_o (mac_sum)
  );

  // MAC step k_q fetches operand pair k_q (for k_q < K) and accumulates the
  // pair fetched on the previous step (for k_q > 0). Step k_q == K therefore
  // only folds in the last product, giving K+1 steps per element; with K == 0
  // the single step adds nothing and the element is the cleared value 0.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    n_d      = n_q;
    k_d      = k_q;
    k_lim_d  = k_lim_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    fin_d    = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (matrices_loaded) begin
          state_d = MAC;
          m_d     = '0;
          n_d     = '0;
          k_d     = '0;
          k_lim_d = K;
          mac_clr = 1'b1;
        end
      end

      MAC: begin
        mac_en = (k_q != '0);
        if (k_q == k_lim_q) begin
          // Capture the sum including the final product straight into the
          // output register so TVALID rises on the cycle after the last add.
          tdata_d  = relu(mac_sum);
          tvalid_d = 1'b1;
          k_d      = '0;
          state_d  = OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      OUT: begin
        if (AXIS_OUT_TREADY) begin
          tvalid_d = 1'b0;
          if ((m_q == M_BITS'(M - 1)) && (n_q == N_BITS'(N - 1))) begin
            state_d = DONE;
            fin_d   = 1'b1;
          end else begin
            if (n_q == N_BITS'(N - 1)) begin
              n_d = '0;
              m_d = m_q + 1'b1;
            end else begin
              n_d = n_q + 1'b1;
            end
            mac_clr = 1'b1;
            state_d = MAC;
          end
        end
      end

      DONE: begin
        // Wait for the load flag to drop so one load yields one compute.
        if (!matrices_loaded) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      k_lim_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      n_q      <= n_d;
      k_q      <= k_d;
      k_lim_q  <= k_lim_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      fin_q    <= fin_d;
    end
  end

  // Addresses are only driven on fetch steps; otherwise they rest at 0.
  always_comb begin
    A_read_addr = '0;
    B_read_addr = '0;
    if ((state_q == MAC) && (k_q != k_lim_q)) begin
      A_read_addr = A_ADDR_BITS'(32'(m_q) * 32'(k_lim_q) + 32'(k_q));
      B_read_addr = B_ADDR_BITS'(32'(k_q) * 32'(N) + 32'(n_q));
    end
  end

  assign AXIS_OUT_TDATA   = tdata_q;
  assign AXIS_OUT_TVALID  = tvalid_q;
  assign compute_finished = fin_q;

endmodule

// File: doc/matmul_compute.md
MATMUL_COMPUTE -- requirements
Module: matmul_compute

Interface
REQ-001 Parameter INW, default 12, signed operand width.
REQ-002 Parameter M, default 7, rows of A and of C.
REQ-003 Parameter N, default 9, columns of B and of C.
REQ-004 Parameter MAXK, default 8, maximum inner dimension.
REQ-005 Localparams: K_BITS=$clog2(MAXK+1), A_ADDR_BITS=$clog2(M*MAXK), B_ADDR_BITS=$clog2(MAXK*N), OUTW=2*INW+$clog2(MAXK).
REQ-006 clk  input  1  single clock; all logic on posedge.
REQ-007 reset  input  1  synchronous, active-low; reset==0 at a posedge resets the block.
REQ-008 matrices_loaded  input  1  A and B memories valid and readable.
REQ-009 K  input  K_BITS  inner dimension; valid while matrices_loaded==1.
REQ-010 A_read_addr  output  A_ADDR_BITS  A memory read address.
REQ-011 A_data  input  INW signed  A memory data, valid one cycle after its address.
REQ-012 B_read_addr  output  B_ADDR_BITS  B memory read address.
REQ-013 B_data  input  INW signed  B memory data, valid one cycle after its address.
REQ-014 compute_finished  output  1  one-cycle pulse when all M*N results are accepted.
REQ-015 AXIS_OUT_TDATA  output  OUTW signed  result element C[m][n].
REQ-016 AXIS_OUT_TVALID  output  1  TDATA valid.
REQ-017 AXIS_OUT_TREADY  input  1  downstream accepts.

Function
REQ-018 A SHALL be addressed row-major M x K: A[m][k] at address m*K+k; B row-major K x N: B[k][n] at address k*N+n.
REQ-019 FSM states SHALL be IDLE, MAC, OUT, DONE.
REQ-020 IDLE->MAC when matrices_loaded==1; m=n=k=0, accumulator cleared.
REQ-021 In MAC, cycle j (j=0..K-1) SHALL drive addresses for k=j; accumulator adds A_data*B_data (full-precision signed) one cycle later; MAC occupies exactly K+1 cycles per element.
REQ-022 MAC->OUT after the last product is accumulated; the registered result drives TDATA with TVALID=1 the next cycle.
REQ-023 TDATA/TVALID SHALL stay stable until TVALID&&TREADY; transfer occurs on that posedge.
REQ-024 On transfer: next element in row-major order (n increments, wraps to 0 with m increment), accumulator cleared, return to MAC; after C[M-1][N-1] go to DONE.
REQ-025 DONE SHALL assert compute_finished for exactly its first cycle, then stay until matrices_loaded==0, then IDLE (no double compute on the same load).
REQ-026 K==0: each element SHALL be 0, one MAC cycle per element, M*N transfers still emitted.
REQ-027 OUTW SHALL guarantee no overflow for K<=MAXK; no saturation logic.
REQ-028 Addresses SHALL be 0 outside MAC.
REQ-029 matrices_loaded falling mid-computation SHALL be ignored; sequence completes.

Reset
REQ-030 On reset==0: state IDLE, m=n=k=0, accumulator 0, TVALID 0, TDATA 0, compute_finished 0, addresses 0.
REQ-031 Reset mid-OUT SHALL drop TVALID the next cycle regardless of TREADY; the pending element is discarded.

Configuration
REQ-032 Macro MATMUL_RELU_EN defined: each negative result SHALL be replaced by 0 before entering the output register; undefined: results pass unmodified. Latency identical both ways.

Structure
REQ-033 Package matmul_pkg SHALL hold the state enum typedef and the OUTW width function.
REQ-034 Sub-module mac_unit (registered multiply-accumulate with clear and enable) SHALL be instantiated once.

Verification
REQ-035 M=2,N=2,K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], TREADY=1 -> TDATA 19,22,43,50, then one compute_finished pulse.
REQ-036 Same data, TREADY low 5 cycles on element 2 -> TDATA 22 held stable with TVALID=1 until accepted; order unchanged.
REQ-037 K=MAXK, all A=B=-2048 (INW=12) -> every element 8*4194304=33554432, no overflow.
REQ-038 MATMUL_RELU_EN, A=[[-1,0],[0,-1]], B=identity -> TDATA 0,0,0,0; without macro -> -1,0,0,-1.
REQ-039 K=0 -> M*N transfers of 0, compute_finished once; matrices_loaded held high afterwards -> no second sequence.
REQ-040 reset=0 during 3rd element of REQ-035 -> TVALID 0 next cycle, IDLE; new load then yields 19,22,43,50.
